// File: rtl/minheap_engine_pkg.sv
// Shared types and defaults for the min-heap priority queue engine.
package minheap_engine_pkg;

  localparam int unsigned WIDTH_DEF  = 8;
  localparam int unsigned DEPTH_DEF  = 16;
  localparam int unsigned SIZE_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_FIN
  } state_t;

  // Datapath action selected by the controller for the current cycle
  typedef enum logic [2:0] {
    A_NONE,
    A_PUSH,
    A_POP,
    A_REPL,
    A_SWAP_UP,
    A_SWAP_DN
  } act_t;

  // Index width for a heap of the given depth (at least one bit)
  function automatic int unsigned idx_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/minheap_engine_if.sv
// Command/status bundle between the SoC glue (master) and the heap engine (slave).
interface minheap_engine_if #(
  parameter int unsigned WIDTH  = minheap_engine_pkg::WIDTH_DEF,
  parameter int unsigned SIZE_W = minheap_engine_pkg::SIZE_W_DEF
) ();

  logic              push;
  logic              pop;
  logic [WIDTH-1:0]  din;
  logic [WIDTH-1:0]  dout;
  logic [SIZE_W-1:0] size;
  logic              valid;
  logic              done;
  logic              busy;
  logic              err;

  modport master (
    output push, pop, din,
    input  dout, size, valid, done, busy, err
  );

  modport slave (
    input  push, pop, din,
    output dout, size, valid, done, busy, err
  );

endinterface

// File: rtl/minheap_engine_min3_sel.sv
// Picks the smallest of a node and its live children for the sift-down step.
// Ties keep the parent, then prefer the left child, so equal keys never move.
module minheap_engine_min3_sel #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned SIZE_W = 8
) (
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [SIZE_W-1:0] i_size,
  input  logic [WIDTH-1:0]  i_key_self,
  input  logic [WIDTH-1:0]  i_key_l,
  input  logic [WIDTH-1:0]  i_key_r,
  output logic [IDX_W-1:0]  o_m_c
);

  localparam int unsigned CH_W = IDX_W + 2;

  logic [CH_W-1:0]  w_left;
  logic [CH_W-1:0]  w_right;
  logic             w_l_live;
  logic             w_r_live;
  logic [WIDTH-1:0] w_best_key;

  assign w_left   = {1'b0, i_idx, 1'b1};
  assign w_right  = w_left + CH_W'(1);
  assign w_l_live = (32'(w_left)  < 32'(i_size));
  assign w_r_live = (32'(w_right) < 32'(i_size));

  // Strict less-than comparisons implement the tie rule
  always_comb begin
    o_m_c      = i_idx;
    w_best_key = i_key_self;
    if (w_l_live && (i_key_l < w_best_key)) begin
      o_m_c      = IDX_W'(w_left);
      w_best_key = i_key_l;
    end
    if (w_r_live && (i_key_r < w_best_key)) begin
      o_m_c = IDX_W'(w_right);
    end
  end

endmodule

// File: rtl/minheap_engine.sv
// Min-priority queue over a register-array binary heap; one compare/swap per clock.
// Push sifts up, pop and replace-top sift down; done pulses once per command.
module minheap_engine
  import minheap_engine_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned SIZE_W = SIZE_W_DEF
) (
  input logic             clk,
  input logic             reset,
  minheap_engine_if.slave bus
);

  localparam int unsigned IDX_W = idx_bits(DEPTH);
  localparam int unsigned CH_W  = IDX_W + 2;

  state_t            r_state;
  state_t            w_next_state;
  act_t              w_act;
  logic              w_rej;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [SIZE_W-1:0] r_size;
  logic [IDX_W-1:0]  r_idx;
  logic              r_valid;
  logic              r_done;
  logic              r_err;
  logic              r_busy;

  logic              w_full;
  logic              w_empty;
  logic [IDX_W-1:0]  w_parent;
  logic [CH_W-1:0]   w_left;
  logic [CH_W-1:0]   w_right;
  logic [WIDTH-1:0]  w_key_cur;
  logic [WIDTH-1:0]  w_key_par;
  logic [WIDTH-1:0]  w_key_l;
  logic [WIDTH-1:0]  w_key_r;
  logic [IDX_W-1:0]  w_m_c;

  assign w_full    = (r_size == SIZE_W'(DEPTH));
  assign w_empty   = (r_size == '0);
  assign w_parent  = (r_idx - IDX_W'(1)) >> 1;
  assign w_left    = {1'b0, r_idx, 1'b1};
  assign w_right   = w_left + CH_W'(1);
  assign w_key_cur = r_mem[r_idx];
  assign w_key_par = r_mem[w_parent];
  // Out-of-range child reads alias a real slot; the selector ignores them as not live
  assign w_key_l   = r_mem[IDX_W'(w_left)];
  assign w_key_r   = r_mem[IDX_W'(w_right)];

  minheap_engine_min3_sel #(
    .WIDTH  (WIDTH),
    .IDX_W  (IDX_W),
    .SIZE_W (SIZE_W)
  ) u_min3_sel (
    .i_idx      (r_idx),
    .i_size     (r_size),
    .i_key_self (w_key_cur),
    .i_key_l    (w_key_l),
    .i_key_r    (w_key_r),
    .o_m_c      (w_m_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and datapath action decode; commands only matter in IDLE
  always_comb begin
    w_next_state = r_state;
    w_act        = A_NONE;
    w_rej        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.push && bus.pop) begin
          if (w_empty) begin
            w_act        = A_PUSH;
            w_next_state = S_UP;
          end else begin
            w_act        = A_REPL;
            w_next_state = S_DOWN;
          end
        end else if (bus.push) begin
          if (w_full) begin
            w_rej        = 1'b1;
            w_next_state = S_FIN;
          end else begin
            w_act        = A_PUSH;
            w_next_state = S_UP;
          end
        end else if (bus.pop) begin
          if (w_empty) begin
            w_rej        = 1'b1;
            w_next_state = S_FIN;
          end else begin
            w_act        = A_POP;
            w_next_state = S_DOWN;
          end
        end
      end
      S_UP: begin
        if ((r_idx == '0) || (w_key_par <= w_key_cur)) begin
          w_next_state = S_FIN;
        end else begin
          w_act = A_SWAP_UP;
        end
      end
      S_DOWN: begin
        if (w_m_c == r_idx) begin
          w_next_state = S_FIN;
        end else begin
          w_act = A_SWAP_DN;
        end
      end
      S_FIN: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Heap storage, occupancy and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_size  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= (w_next_state == S_FIN);
      r_err  <= w_rej;
      r_busy <= (w_next_state != S_IDLE);
      case (w_act)
        A_PUSH: begin
          r_mem[IDX_W'(r_size)] <= bus.din;
          r_idx                 <= IDX_W'(r_size);
          r_size                <= r_size + SIZE_W'(1);
          r_valid               <= 1'b1;
        end
        A_POP: begin
          r_mem[0] <= r_mem[IDX_W'(r_size - SIZE_W'(1))];
          r_idx    <= '0;
          r_size   <= r_size - SIZE_W'(1);
          r_valid  <= (r_size != SIZE_W'(1));
        end
        A_REPL: begin
          r_mem[0] <= bus.din;
          r_idx    <= '0;
        end
        A_SWAP_UP: begin
          r_mem[w_parent] <= w_key_cur;
          r_mem[r_idx]    <= w_key_par;
          r_idx           <= w_parent;
        end
        A_SWAP_DN: begin
          r_mem[w_m_c] <= w_key_cur;
          r_mem[r_idx] <= r_mem[w_m_c];
          r_idx        <= w_m_c;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.dout  = r_mem[0];
  assign bus.size  = r_size;
  assign bus.valid = r_valid;
  assign bus.done  = r_done;
  assign bus.busy  = r_busy;
  assign bus.err   = r_err;

endmodule

// File: tb/tb_minheap_engine.sv
// Bench for minheap_engine: directed scenarios plus a randomized mix checked
// against a multiset model (queue of keys; expected top = smallest key held).
module tb_minheap_engine;

  localparam int DEPTH = 16;
  localparam int LOG2D = 4;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   q[$];

  minheap_engine_if #(.WIDTH(8), .SIZE_W(8)) bus ();

  minheap_engine #(.WIDTH(8), .DEPTH(DEPTH), .SIZE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic int model_min();
    int m = 1000;
    foreach (q[i]) if (q[i] < m) m = q[i];
    return m;
  endfunction

  function automatic void model_pop();
    int m = model_min();
    foreach (q[i]) begin
      if (q[i] == m) begin
        q.delete(i);
        return;
      end
    end
  endfunction

  task automatic apply_reset();
    @(negedge clk) reset = 1'b1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    @(negedge clk) reset = 1'b0;
    q.delete();
  endtask

  // Issue one command; lat = number of rising edges from accept to done seen high
  task automatic do_cmd(input logic p, input logic po, input logic [7:0] d, output int lat);
    @(negedge clk);
    bus.push = p;
    bus.pop  = po;
    bus.din  = d;
    @(posedge clk);
    @(negedge clk);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    if (bus.done !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", lat);
      lat = -1;
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.din  = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.size, bus.valid, bus.busy, bus.done, bus.err, bus.dout} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_state: got size=%0d valid=%b busy=%b done=%b err=%b dout=%0d, required all 0",
               bus.size, bus.valid, bus.busy, bus.done, bus.err, bus.dout);
    end
    reset = 1'b0;
    q.delete();
  endtask

  task automatic test_pop_empty();
    int lat;
    do_cmd(1'b0, 1'b1, 8'd0, lat);
    vectors++;
    if (lat !== 1 || bus.err !== 1'b1 || bus.size !== 8'd0 || bus.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pop_empty: got lat=%0d err=%b size=%0d valid=%b, required lat=1 err=1 size=0 valid=0",
               lat, bus.err, bus.size, bus.valid);
    end
  endtask

  task automatic test_single_swap();
    int lat;
    apply_reset();
    do_cmd(1'b1, 1'b0, 8'd9, lat);
    do_cmd(1'b1, 1'b0, 8'd1, lat);
    vectors++;
    if (lat !== 3 || bus.dout !== 8'd1 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL single_swap: got lat=%0d dout=%0d err=%b, required lat=3 dout=1 err=0", lat, bus.dout, bus.err);
    end
  endtask

  task automatic test_push_pop_seq();
    int lat;
    int keys[4]     = '{9, 4, 7, 1};
    int exp_lat[4]  = '{2, 3, 2, 4};
    int exp_top[4]  = '{9, 4, 4, 1};
    int after_pop[3] = '{4, 7, 9};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b1, 1'b0, 8'(keys[i]), lat);
      vectors++;
      if (lat !== exp_lat[i] || bus.dout !== 8'(exp_top[i]) || bus.size !== 8'(i + 1)) begin
        miscompares++;
        $display("FAIL push_seq[%0d]: got lat=%0d dout=%0d size=%0d, required lat=%0d dout=%0d size=%0d",
                 i, lat, bus.dout, bus.size, exp_lat[i], exp_top[i], i + 1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b0, 1'b1, 8'd0, lat);
      vectors++;
      if (i < 3) begin
        if (bus.dout !== 8'(after_pop[i]) || bus.size !== 8'(3 - i) || bus.valid !== 1'b1) begin
          miscompares++;
          $display("FAIL pop_seq[%0d]: got dout=%0d size=%0d valid=%b, required dout=%0d size=%0d valid=1",
                   i, bus.dout, bus.size, bus.valid, after_pop[i], 3 - i);
        end
      end else if (bus.valid !== 1'b0 || bus.size !== 8'd0 || bus.err !== 1'b0) begin
        miscompares++;
        $display("FAIL pop_last: got valid=%b size=%0d err=%b, required valid=0 size=0 err=0",
                 bus.valid, bus.size, bus.err);
      end
    end
  endtask

  task automatic test_fill_drain();
    int lat;
    int k;
    int prev;
    int ret;
    int exp;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      k = int'($urandom_range(0, 255));
      do_cmd(1'b1, 1'b0, 8'(k), lat);
      q.push_back(k);
      vectors++;
      if (bus.size !== 8'(q.size()) || bus.dout !== 8'(model_min()) || bus.err !== 1'b0 ||
          lat < 2 || lat > 2 + LOG2D) begin
        miscompares++;
        $display("FAIL fill[%0d]: got size=%0d dout=%0d err=%b lat=%0d, required size=%0d dout=%0d err=0 lat 2..%0d",
                 i, bus.size, bus.dout, bus.err, lat, q.size(), model_min(), 2 + LOG2D);
      end
    end
    do_cmd(1'b1, 1'b0, 8'd0, lat);
    vectors++;
    if (lat !== 1 || bus.err !== 1'b1 || bus.size !== 8'(DEPTH) || bus.dout !== 8'(model_min())) begin
      miscompares++;
      $display("FAIL push_full: got lat=%0d err=%b size=%0d dout=%0d, required lat=1 err=1 size=%0d dout=%0d",
               lat, bus.err, bus.size, bus.dout, DEPTH, model_min());
    end
    prev = 0;
    for (int i = 0; i < DEPTH; i++) begin
      exp = model_min();
      ret = int'(bus.dout);
      do_cmd(1'b0, 1'b1, 8'd0, lat);
      model_pop();
      vectors++;
      if (ret !== exp || ret < prev || bus.size !== 8'(q.size()) || lat < 2 || lat > 2 + LOG2D) begin
        miscompares++;
        $display("FAIL drain[%0d]: got key=%0d prev=%0d size=%0d lat=%0d, required key=%0d nondecreasing size=%0d",
                 i, ret, prev, bus.size, lat, exp, q.size());
      end
      prev = ret;
    end
    vectors++;
    if (bus.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_valid: got valid=%b, required 0", bus.valid);
    end
  endtask

  task automatic test_replace();
    int lat;
    int ret;
    int keys[3] = '{2, 6, 8};
    apply_reset();
    for (int i = 0; i < 3; i++) do_cmd(1'b1, 1'b0, 8'(keys[i]), lat);
    ret = int'(bus.dout);
    do_cmd(1'b1, 1'b1, 8'd5, lat);
    vectors++;
    if (ret !== 2 || bus.size !== 8'd3 || bus.dout !== 8'd5 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL replace_top: got ret=%0d size=%0d dout=%0d err=%b, required ret=2 size=3 dout=5 err=0",
               ret, bus.size, bus.dout, bus.err);
    end
    apply_reset();
    do_cmd(1'b1, 1'b1, 8'd5, lat);
    vectors++;
    if (bus.size !== 8'd1 || bus.dout !== 8'd5 || bus.valid !== 1'b1 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL replace_empty: got size=%0d dout=%0d valid=%b err=%b, required size=1 dout=5 valid=1 err=0",
               bus.size, bus.dout, bus.valid, bus.err);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    apply_reset();
    do_cmd(1'b1, 1'b0, 8'd3, lat);
    // Still in the done cycle: this push must be ignored
    bus.push = 1'b1;
    bus.din  = 8'd0;
    @(posedge clk);
    @(negedge clk);
    bus.push = 1'b0;
    vectors++;
    if (bus.size !== 8'd1 || bus.dout !== 8'd3 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ignored: got size=%0d dout=%0d busy=%b done=%b, required size=1 dout=3 busy=0 done=0",
               bus.size, bus.dout, bus.busy, bus.done);
    end
    do_cmd(1'b1, 1'b0, 8'd0, lat);
    vectors++;
    if (bus.size !== 8'd2 || bus.dout !== 8'd0 || lat !== 3) begin
      miscompares++;
      $display("FAIL b2b_next: got size=%0d dout=%0d lat=%0d, required size=2 dout=0 lat=3",
               bus.size, bus.dout, lat);
    end
  endtask

  task automatic test_reset_mid_sift();
    int lat;
    int keys[5] = '{10, 20, 30, 40, 50};
    apply_reset();
    for (int i = 0; i < 5; i++) do_cmd(1'b1, 1'b0, 8'(keys[i]), lat);
    @(negedge clk);
    bus.pop = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.pop = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.size !== 8'd4) begin
      miscompares++;
      $display("FAIL mid_sift_busy: got busy=%b size=%0d, required busy=1 size=4", bus.busy, bus.size);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.size, bus.busy, bus.done, bus.valid, bus.dout} !== 19'd0) begin
      miscompares++;
      $display("FAIL mid_sift_reset: got size=%0d busy=%b done=%b valid=%b dout=%0d, required all 0",
               bus.size, bus.busy, bus.done, bus.valid, bus.dout);
    end
    reset = 1'b0;
    q.delete();
    do_cmd(1'b1, 1'b0, 8'd3, lat);
    vectors++;
    if (bus.dout !== 8'd3 || bus.size !== 8'd1) begin
      miscompares++;
      $display("FAIL post_reset_push: got dout=%0d size=%0d, required dout=3 size=1", bus.dout, bus.size);
    end
  endtask

  task automatic test_random_mix();
    int   lat;
    int   op;
    int   k;
    int   ret;
    logic p;
    logic po;
    logic exp_err;
    apply_reset();
    for (int n = 0; n < 150; n++) begin
      op = int'($urandom_range(0, 3));
      k  = int'($urandom_range(0, 31));
      p  = (op != 2);
      po = (op >= 2);
      exp_err = (p && !po && q.size() == DEPTH) || (!p && po && q.size() == 0);
      ret = int'(bus.dout);
      do_cmd(p, po, 8'(k), lat);
      vectors++;
      if (bus.err !== exp_err || (exp_err && lat !== 1) || (!exp_err && (lat < 2 || lat > 2 + LOG2D))) begin
        miscompares++;
        $display("FAIL mix_err[%0d]: got err=%b lat=%0d, required err=%b", n, bus.err, lat, exp_err);
      end
      if (!exp_err) begin
        if (po && q.size() != 0) begin
          vectors++;
          if (ret !== model_min()) begin
            miscompares++;
            $display("FAIL mix_ret[%0d]: got %0d, required %0d", n, ret, model_min());
          end
          model_pop();
        end
        if (p) q.push_back(k);
      end
      vectors++;
      if (bus.size !== 8'(q.size()) || bus.valid !== (q.size() != 0) ||
          (q.size() != 0 && bus.dout !== 8'(model_min()))) begin
        miscompares++;
        $display("FAIL mix_state[%0d]: got size=%0d valid=%b dout=%0d, required size=%0d min=%0d",
                 n, bus.size, bus.valid, bus.dout, q.size(), model_min());
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_pop_empty();
    test_single_swap();
    test_push_pop_seq();
    test_fill_drain();
    test_replace();
    test_back_to_back();
    test_reset_mid_sift();
    test_random_mix();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
